// File: rtl/keccak_pad_absorb.sv
// Keccak/SHA-3 message padder and rate-block assembler.
// Packs 64-bit message lanes into rate-sized blocks and applies domain padding.
module keccak_pad_absorb #(
    parameter int MAX_RATE_LANES = 21
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [2:0]                   mode_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [63:0]                  in_data_i,
    input  logic [7:0]                   in_keep_i,
    input  logic                         in_last_i,
    output logic                         blk_valid_o,
    input  logic                         blk_ready_i,
    output logic [MAX_RATE_LANES*64-1:0] blk_data_o,
    output logic [4:0]                   blk_lanes_o,
    output logic                         blk_last_o
);

    localparam int W = MAX_RATE_LANES * 64;

    localparam logic [2:0] SHA3_256 = 3'd0;
    localparam logic [2:0] SHA3_512 = 3'd1;
    localparam logic [2:0] SHAKE128 = 3'd2;
    localparam logic [2:0] SHAKE256 = 3'd3;

    typedef enum logic [1:0] {IDLE, ABSORB, EMIT} state_t;

    state_t       state, state_n;
    logic [W-1:0] blk_q, blk_n;
    logic [4:0]   lane_cnt, lane_n;
    logic [4:0]   rate_q, rate_n;
    logic [7:0]   pad_q, pad_n;
    logic         pend_q, pend_n;
    logic         last_q, last_n;
    logic [63:0]  lane_data;
    logic [3:0]   nbytes;
    int           cur_i, top_i;

    function automatic logic [4:0] rate_of(input logic [2:0] m);
        unique case (m)
            SHA3_512: rate_of = 5'd9;
            SHAKE128: rate_of = 5'd21;
            default:  rate_of = 5'd17;
        endcase
    endfunction

    function automatic logic [7:0] pad_of(input logic [2:0] m);
        pad_of = (m == SHAKE128 || m == SHAKE256) ? 8'h1F : 8'h06;
    endfunction

    // Bytes beyond the keep mask only get cleared on the final lane.
    always_comb begin
        lane_data = in_data_i;
        nbytes    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_last_i && !in_keep_i[i])
                lane_data[i*8 +: 8] = 8'h00;
            if (in_keep_i[i])
                nbytes = nbytes + 4'd1;
        end
    end

    assign cur_i = int'(lane_cnt);
    assign top_i = int'(rate_q) - 1;

    always_comb begin
        state_n = state;
        blk_n   = blk_q;
        lane_n  = lane_cnt;
        rate_n  = rate_q;
        pad_n   = pad_q;
        pend_n  = pend_q;
        last_n  = last_q;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = ABSORB;
                    rate_n  = rate_of(mode_i);
                    pad_n   = pad_of(mode_i);
                    blk_n   = '0;
                    lane_n  = 5'd0;
                    pend_n  = 1'b0;
                    last_n  = 1'b0;
                end
            end
            ABSORB: begin
                if (in_valid_i) begin
                    blk_n[cur_i*64 +: 64] = lane_data;
                    if (!in_last_i) begin
                        lane_n = lane_cnt + 5'd1;
                        if (cur_i == top_i) begin
                            state_n = EMIT;
                            last_n  = 1'b0;
                        end
                    end else if (in_keep_i != 8'hFF) begin
                        blk_n[cur_i*64 + int'(nbytes)*8 +: 8] =
                            blk_n[cur_i*64 + int'(nbytes)*8 +: 8] | pad_q;
                        blk_n[top_i*64 + 56 +: 8] =
                            blk_n[top_i*64 + 56 +: 8] | 8'h80;
                        state_n = EMIT;
                        last_n  = 1'b1;
                    end else if (cur_i != top_i) begin
                        blk_n[(cur_i+1)*64 +: 8] =
                            blk_n[(cur_i+1)*64 +: 8] | pad_q;
                        blk_n[top_i*64 + 56 +: 8] =
                            blk_n[top_i*64 + 56 +: 8] | 8'h80;
                        state_n = EMIT;
                        last_n  = 1'b1;
                    end else begin
                        // Full final block: padding spills into its own block.
                        state_n = EMIT;
                        last_n  = 1'b0;
                        pend_n  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (blk_ready_i) begin
                    if (last_q) begin
                        state_n = IDLE;
                        last_n  = 1'b0;
                    end else if (pend_q) begin
                        blk_n       = '0;
                        blk_n[7:0]  = pad_q;
                        blk_n[top_i*64 + 56 +: 8] =
                            blk_n[top_i*64 + 56 +: 8] | 8'h80;
                        pend_n      = 1'b0;
                        last_n      = 1'b1;
                    end else begin
                        blk_n   = '0;
                        lane_n  = 5'd0;
                        state_n = ABSORB;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            blk_q    <= '0;
            lane_cnt <= 5'd0;
            rate_q   <= 5'd0;
            pad_q    <= 8'h00;
            pend_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_n;
            blk_q    <= blk_n;
            lane_cnt <= lane_n;
            rate_q   <= rate_n;
            pad_q    <= pad_n;
            pend_q   <= pend_n;
            last_q   <= last_n;
        end
    end

    assign blk_data_o  = blk_q;
    assign blk_lanes_o = rate_q;
    assign blk_last_o  = last_q;
    assign blk_valid_o = (state == EMIT);
    assign in_ready_o  = (state == ABSORB);

endmodule

// File: tb/tb_keccak_pad_absorb.sv
// Directed self-checking bench for keccak_pad_absorb.
// Each scenario task drives a message and checks the emitted blocks inline.
module tb_keccak_pad_absorb;

    localparam int L = 21;
    localparam int W = L * 64;
    localparam logic [2:0] M_SHA3_256 = 3'd0;
    localparam logic [2:0] M_SHA3_512 = 3'd1;
    localparam logic [2:0] M_SHAKE128 = 3'd2;
    localparam logic [2:0] M_SHAKE256 = 3'd3;
    localparam logic [63:0] TOP = 64'h8000000000000000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [2:0]   mode_i = 3'd0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [63:0]  in_data_i = '0;
    logic [7:0]   in_keep_i = '0;
    logic         in_last_i = 1'b0;
    logic         blk_valid_o;
    logic         blk_ready_i = 1'b0;
    logic [W-1:0] blk_data_o;
    logic [4:0]   blk_lanes_o;
    logic         blk_last_o;

    int checks = 0;
    int fails  = 0;
    logic [W-1:0] exp;
    logic [W-1:0] snap;
    int d;

    keccak_pad_absorb #(.MAX_RATE_LANES(L)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_keep_i(in_keep_i),
        .in_last_i(in_last_i), .blk_valid_o(blk_valid_o),
        .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_o),
        .blk_lanes_o(blk_lanes_o), .blk_last_o(blk_last_o)
    );

    always #5 clk = ~clk;

    function automatic int diff_lane(input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        for (int i = 0; i < L; i++)
            if (a[i*64 +: 64] !== b[i*64 +: 64]) return i;
        return 0;
    endfunction

    task automatic start_msg(input logic [2:0] m);
        start_i = 1'b1;
        mode_i  = m;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_lane(input logic [63:0] dat, input logic [7:0] keep,
                             input logic last);
        in_valid_i = 1'b1;
        in_data_i  = dat;
        in_keep_i  = keep;
        in_last_i  = last;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic accept_blk();
        blk_ready_i = 1'b1;
        @(posedge clk); #1;
        blk_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b0 ||
            blk_last_o !== 1'b0 || blk_lanes_o !== 5'd0) begin
            fails++;
            $display("FAIL reset_ctl got v=%b r=%b l=%b n=%0d exp all zero",
                     blk_valid_o, in_ready_o, blk_last_o, blk_lanes_o);
        end
        checks++;
        if (blk_data_o !== '0) begin
            fails++;
            $display("FAIL reset_data got nonzero exp zero");
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_sha3_256_empty(input string nm);
        start_msg(M_SHA3_256);
        checks++;
        if (in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready got %b exp 1", nm, in_ready_o);
        end
        send_lane(64'hDEADBEEFDEADBEEF, 8'h00, 1'b1);
        exp = '0;
        exp[0*64 +: 64]  = 64'h06;
        exp[16*64 +: 64] = TOP;
        checks++;
        if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b1 ||
            blk_lanes_o !== 5'd17) begin
            fails++;
            $display("FAIL %s_ctl got v=%b l=%b n=%0d exp 1 1 17",
                     nm, blk_valid_o, blk_last_o, blk_lanes_o);
        end
        checks++;
        if (blk_data_o !== exp) begin
            fails++;
            d = diff_lane(blk_data_o, exp);
            $display("FAIL %s_data lane %0d got %h exp %h", nm, d,
                     blk_data_o[d*64 +: 64], exp[d*64 +: 64]);
        end
        accept_blk();
        checks++;
        if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle got v=%b r=%b exp 0 0",
                     nm, blk_valid_o, in_ready_o);
        end
    endtask

    task automatic test_full_spill();
        start_msg(M_SHAKE128);
        exp = '0;
        for (int i = 0; i < 21; i++) begin
            exp[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 1);
            send_lane(exp[i*64 +: 64], 8'hFF, i == 20);
        end
        checks++;
        if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b0 ||
            blk_lanes_o !== 5'd21) begin
            fails++;
            $display("FAIL spill_b1_ctl got v=%b l=%b n=%0d exp 1 0 21",
                     blk_valid_o, blk_last_o, blk_lanes_o);
        end
        checks++;
        if (blk_data_o !== exp) begin
            fails++;
            d = diff_lane(blk_data_o, exp);
            $display("FAIL spill_b1_data lane %0d got %h exp %h", d,
                     blk_data_o[d*64 +: 64], exp[d*64 +: 64]);
        end
        accept_blk();
        exp = '0;
        exp[0*64 +: 64]  = 64'h1F;
        exp[20*64 +: 64] = TOP;
        checks++;
        if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b1) begin
            fails++;
            $display("FAIL spill_b2_ctl got v=%b l=%b exp 1 1",
                     blk_valid_o, blk_last_o);
        end
        checks++;
        if (blk_data_o !== exp) begin
            fails++;
            d = diff_lane(blk_data_o, exp);
            $display("FAIL spill_b2_data lane %0d got %h exp %h", d,
                     blk_data_o[d*64 +: 64], exp[d*64 +: 64]);
        end
        accept_blk();
        checks++;
        if (blk_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL spill_idle got v=%b exp 0", blk_valid_o);
        end
    endtask

    task automatic test_shared_byte();
        start_msg(M_SHA3_512);
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            exp[i*64 +: 64] = 64'h5150_0000_0000_0000 | 64'(i);
            send_lane(exp[i*64 +: 64], 8'hFF, 1'b0);
        end
        send_lane(64'h00AABBCCDDEEFF11, 8'h7F, 1'b1);
        exp[8*64 +: 64] = 64'h86AABBCCDDEEFF11;
        checks++;
        if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b1 ||
            blk_lanes_o !== 5'd9) begin
            fails++;
            $display("FAIL shared_ctl got v=%b l=%b n=%0d exp 1 1 9",
                     blk_valid_o, blk_last_o, blk_lanes_o);
        end
        checks++;
        if (blk_data_o !== exp) begin
            fails++;
            d = diff_lane(blk_data_o, exp);
            $display("FAIL shared_data lane %0d got %h exp %h", d,
                     blk_data_o[d*64 +: 64], exp[d*64 +: 64]);
        end
        accept_blk();
    endtask

    task automatic test_partial_and_next_lane();
        start_msg(M_SHAKE256);
        send_lane(64'h1122334455667788, 8'h0F, 1'b1);
        exp = '0;
        exp[0*64 +: 64]  = 64'h0000001F55667788;
        exp[16*64 +: 64] = TOP;
        checks++;
        if (blk_data_o !== exp || blk_last_o !== 1'b1) begin
            fails++;
            d = diff_lane(blk_data_o, exp);
            $display("FAIL partial_data lane %0d got %h exp %h last %b", d,
                     blk_data_o[d*64 +: 64], exp[d*64 +: 64], blk_last_o);
        end
        accept_blk();
        start_msg(M_SHA3_256);
        send_lane(64'hFEDCBA9876543210, 8'hFF, 1'b1);
        exp = '0;
        exp[0*64 +: 64]  = 64'hFEDCBA9876543210;
        exp[1*64 +: 64]  = 64'h06;
        exp[16*64 +: 64] = TOP;
        checks++;
        if (blk_data_o !== exp || blk_last_o !== 1'b1) begin
            fails++;
            d = diff_lane(blk_data_o, exp);
            $display("FAIL nextlane_data lane %0d got %h exp %h last %b", d,
                     blk_data_o[d*64 +: 64], exp[d*64 +: 64], blk_last_o);
        end
        accept_blk();
    endtask

    task automatic test_back_to_back_stall();
        start_msg(M_SHA3_512);
        exp = '0;
        start_i = 1'b1;
        mode_i  = M_SHAKE128;
        for (int i = 0; i < 9; i++) begin
            exp[i*64 +: 64] = 64'hA0A0_0000_0000_0000 | 64'(i + 16);
            send_lane(exp[i*64 +: 64], 8'hFF, 1'b0);
        end
        start_i = 1'b0;
        checks++;
        if (blk_valid_o !== 1'b1 || blk_last_o !== 1'b0 ||
            blk_lanes_o !== 5'd9) begin
            fails++;
            $display("FAIL stall_ctl got v=%b l=%b n=%0d exp 1 0 9",
                     blk_valid_o, blk_last_o, blk_lanes_o);
        end
        snap = blk_data_o;
        checks++;
        if (snap !== exp) begin
            fails++;
            d = diff_lane(snap, exp);
            $display("FAIL stall_data lane %0d got %h exp %h", d,
                     snap[d*64 +: 64], exp[d*64 +: 64]);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (blk_data_o !== exp || in_ready_o !== 1'b0 ||
                blk_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold cyc %0d got r=%b v=%b exp 0 1",
                         c, in_ready_o, blk_valid_o);
            end
        end
        accept_blk();
        checks++;
        if (in_ready_o !== 1'b1 || blk_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL stall_resume got r=%b v=%b exp 1 0",
                     in_ready_o, blk_valid_o);
        end
        send_lane(64'h0, 8'h00, 1'b1);
        exp = '0;
        exp[0*64 +: 64] = 64'h06;
        exp[8*64 +: 64] = TOP;
        checks++;
        if (blk_data_o !== exp || blk_last_o !== 1'b1) begin
            fails++;
            d = diff_lane(blk_data_o, exp);
            $display("FAIL stall_tail lane %0d got %h exp %h last %b", d,
                     blk_data_o[d*64 +: 64], exp[d*64 +: 64], blk_last_o);
        end
        accept_blk();
    endtask

    task automatic test_mid_reset();
        start_msg(M_SHAKE256);
        for (int i = 0; i < 3; i++)
            send_lane(64'h7777_0000_0000_0000 | 64'(i), 8'hFF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b0 || blk_valid_o !== 1'b0 ||
            blk_last_o !== 1'b0 || blk_lanes_o !== 5'd0 ||
            blk_data_o !== '0) begin
            fails++;
            $display("FAIL midrst got r=%b v=%b l=%b n=%0d exp all zero",
                     in_ready_o, blk_valid_o, blk_last_o, blk_lanes_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        test_sha3_256_empty("post_rst");
    endtask

    initial begin
        test_reset();
        test_sha3_256_empty("empty");
        test_full_spill();
        test_shared_byte();
        test_partial_and_next_lane();
        test_back_to_back_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
